// File: rtl/mem_ahb_master.sv
`default_nettype none
// ============================================================================
//  Module   : mem_ahb_master
//  Purpose  : Bridges a simple level-request memory port onto an AHB-Lite
//             master, one transfer at a time (no address pipelining).
//  Revision : 1.0 - initial release
// ============================================================================
module mem_ahb_master #(
    parameter int          ADDR_W    = 16,
    parameter logic [31:0] BASE_ADDR = 32'h2000_0000
) (
    input  logic              Clk,
    input  logic              Resetn,
    // requester side
    input  logic [ADDR_W-1:0] maddr,
    input  logic [1:0]        msize,
    input  logic [31:0]       mwdata,
    input  logic              mread,
    input  logic              mwrite,
    output logic [31:0]       mrdata,
    output logic              mready,
    output logic              merror,
    // AHB-Lite master
    output logic [31:0]       HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [1:0]        HSIZE,
    output logic [31:0]       HWDATA,
    output logic              HSEL,
    output logic              HMASTLOCK,
    input  logic              HREADY,
    input  logic [31:0]       HRDATA,
    input  logic              HRESP
);

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_ADDR = 3'd1;
    localparam logic [2:0] c_ST_DATA = 3'd2;
    localparam logic [2:0] c_ST_ERR  = 3'd3;
    localparam logic [2:0] c_ST_DONE = 3'd4;

    localparam logic [1:0] c_HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] c_HTRANS_NONSEQ = 2'b10;

    logic [2:0]  r_state;
    logic [31:0] r_haddr;
    logic [1:0]  r_hsize;
    logic        r_hwrite;
    logic [31:0] r_hwdata;
    logic [31:0] r_mrdata;
    logic        r_mready;
    logic        r_merror;

    logic        w_illegal;
    logic [31:0] w_wdata_rep;
    logic [31:0] w_rdata_sel;
    logic [31:0] w_addr_ext;

    assign w_addr_ext = {{(32 - ADDR_W){1'b0}}, maddr};

    // Simultaneous read+write, reserved size or misaligned address never reach the bus.
    assign w_illegal = (mread && mwrite)
                     || (msize == 2'b11)
                     || ((msize == 2'b01) && maddr[0])
                     || ((msize == 2'b10) && (maddr[1:0] != 2'b00));

    always_comb begin
        w_wdata_rep = mwdata;
        case (msize)
            2'b00:   w_wdata_rep = {4{mwdata[7:0]}};
            2'b01:   w_wdata_rep = {2{mwdata[15:0]}};
            default: w_wdata_rep = mwdata;
        endcase
    end

    // Read lanes are picked from the bus address actually issued, not maddr.
    always_comb begin
        w_rdata_sel = HRDATA;
        case (r_hsize)
            2'b00: begin
                case (r_haddr[1:0])
                    2'b00:   w_rdata_sel = {24'h0, HRDATA[7:0]};
                    2'b01:   w_rdata_sel = {24'h0, HRDATA[15:8]};
                    2'b10:   w_rdata_sel = {24'h0, HRDATA[23:16]};
                    default: w_rdata_sel = {24'h0, HRDATA[31:24]};
                endcase
            end
            2'b01:   w_rdata_sel = r_haddr[1] ? {16'h0, HRDATA[31:16]} : {16'h0, HRDATA[15:0]};
            default: w_rdata_sel = HRDATA;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Resetn) begin
            r_state  <= c_ST_IDLE;
            r_haddr  <= BASE_ADDR;
            r_hsize  <= 2'b00;
            r_hwrite <= 1'b0;
            r_hwdata <= 32'h0;
            r_mrdata <= 32'h0;
            r_mready <= 1'b0;
            r_merror <= 1'b0;
        end else begin
            r_mready <= 1'b0;
            r_merror <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (mread || mwrite) begin
                        if (w_illegal) begin
                            r_state  <= c_ST_DONE;
                            r_mready <= 1'b1;
                            r_merror <= 1'b1;
                        end else begin
                            r_haddr  <= BASE_ADDR + w_addr_ext;
                            r_hsize  <= msize;
                            r_hwrite <= mwrite;
                            r_hwdata <= w_wdata_rep;
                            r_state  <= c_ST_ADDR;
                        end
                    end
                end
                c_ST_ADDR: begin
                    if (HREADY) begin
                        r_state <= c_ST_DATA;
                    end
                end
                c_ST_DATA: begin
                    if (HRESP) begin
                        // A single-cycle error is a protocol slip by the slave; still report it.
                        if (HREADY) begin
                            r_state  <= c_ST_DONE;
                            r_mready <= 1'b1;
                            r_merror <= 1'b1;
                        end else begin
                            r_state <= c_ST_ERR;
                        end
                    end else if (HREADY) begin
                        if (!r_hwrite) begin
                            r_mrdata <= w_rdata_sel;
                        end
                        r_state  <= c_ST_DONE;
                        r_mready <= 1'b1;
                    end
                end
                c_ST_ERR: begin
                    if (HREADY) begin
                        r_state  <= c_ST_DONE;
                        r_mready <= 1'b1;
                        r_merror <= 1'b1;
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign HTRANS    = (r_state == c_ST_ADDR) ? c_HTRANS_NONSEQ : c_HTRANS_IDLE;
    assign HADDR     = r_haddr;
    assign HSIZE     = r_hsize;
    assign HWRITE    = r_hwrite;
    assign HWDATA    = r_hwdata;
    assign HSEL      = 1'b1;
    assign HMASTLOCK = 1'b0;
    assign mrdata    = r_mrdata;
    assign mready    = r_mready;
    assign merror    = r_merror;

endmodule
`default_nettype wire

// File: tb/tb_mem_ahb_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_ahb_master
//  Purpose  : Directed self-checking bench for mem_ahb_master.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_ahb_master;

    logic        Clk;
    logic        Resetn;
    logic [15:0] maddr;
    logic [1:0]  msize;
    logic [31:0] mwdata;
    logic        mread;
    logic        mwrite;
    logic [31:0] mrdata;
    logic        mready;
    logic        merror;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [1:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HSEL;
    logic        HMASTLOCK;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HRESP;

    int n_cmp = 0;
    int n_err = 0;

    mem_ahb_master #(
        .ADDR_W    (16),
        .BASE_ADDR (32'h2000_0000)
    ) u_dut (
        .Clk       (Clk),
        .Resetn    (Resetn),
        .maddr     (maddr),
        .msize     (msize),
        .mwdata    (mwdata),
        .mread     (mread),
        .mwrite    (mwrite),
        .mrdata    (mrdata),
        .mready    (mready),
        .merror    (merror),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HWDATA    (HWDATA),
        .HSEL      (HSEL),
        .HMASTLOCK (HMASTLOCK),
        .HREADY    (HREADY),
        .HRDATA    (HRDATA),
        .HRESP     (HRESP)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge Clk);
    endtask

    int nonseq_since;
    int n_nonseq;
    int n_pulse;

    initial begin
        Resetn = 1'b0;
        maddr  = 16'h0;
        msize  = 2'b00;
        mwdata = 32'h0;
        mread  = 1'b0;
        mwrite = 1'b0;
        HREADY = 1'b1;
        HRDATA = 32'h0;
        HRESP  = 1'b0;

        // ---------------- reset values ----------------
        step(); step(); step();
        check_eq("rst_htrans", {30'h0, HTRANS}, 32'h0);
        check_eq("rst_haddr", HADDR, 32'h2000_0000);
        check_eq("rst_hsize", {30'h0, HSIZE}, 32'h0);
        check_eq("rst_hwrite", {31'h0, HWRITE}, 32'h0);
        check_eq("rst_hwdata", HWDATA, 32'h0);
        check_eq("rst_mrdata", mrdata, 32'h0);
        check_eq("rst_mready", {31'h0, mready}, 32'h0);
        check_eq("rst_merror", {31'h0, merror}, 32'h0);
        check_eq("hsel", {31'h0, HSEL}, 32'h1);
        check_eq("hmastlock", {31'h0, HMASTLOCK}, 32'h0);
        Resetn = 1'b1;
        step();

        // ---------------- byte read, zero wait ----------------
        maddr = 16'h0003; msize = 2'b00; mread = 1'b1;
        HREADY = 1'b1; HRDATA = 32'hAABB_CCDD;
        step();  // cycle 1
        check_eq("br_htrans_c1", {30'h0, HTRANS}, 32'h2);
        check_eq("br_haddr", HADDR, 32'h2000_0003);
        check_eq("br_hsize", {30'h0, HSIZE}, 32'h0);
        check_eq("br_hwrite", {31'h0, HWRITE}, 32'h0);
        check_eq("br_mready_c1", {31'h0, mready}, 32'h0);
        step();  // cycle 2
        check_eq("br_htrans_c2", {30'h0, HTRANS}, 32'h0);
        check_eq("br_mready_c2", {31'h0, mready}, 32'h0);
        step();  // cycle 3
        check_eq("br_mready_c3", {31'h0, mready}, 32'h1);
        check_eq("br_merror", {31'h0, merror}, 32'h0);
        check_eq("br_mrdata", mrdata, 32'h0000_00AA);
        mread = 1'b0;
        step();  // cycle 4
        check_eq("br_mready_c4", {31'h0, mready}, 32'h0);

        // ---------------- halfword write, two wait states ----------------
        maddr = 16'h0102; msize = 2'b01; mwdata = 32'h0000_1234; mwrite = 1'b1;
        HREADY = 1'b1; HRDATA = 32'h5555_6666;
        step();  // cycle 1
        check_eq("hw_htrans_c1", {30'h0, HTRANS}, 32'h2);
        check_eq("hw_haddr", HADDR, 32'h2000_0102);
        check_eq("hw_hsize", {30'h0, HSIZE}, 32'h1);
        check_eq("hw_hwrite", {31'h0, HWRITE}, 32'h1);
        step();  // cycle 2
        check_eq("hw_htrans_c2", {30'h0, HTRANS}, 32'h0);
        check_eq("hw_hwdata_c2", HWDATA, 32'h1234_1234);
        HREADY = 1'b0;
        step();  // cycle 3
        check_eq("hw_hwdata_c3", HWDATA, 32'h1234_1234);
        check_eq("hw_mready_c3", {31'h0, mready}, 32'h0);
        step();  // cycle 4
        check_eq("hw_hwdata_c4", HWDATA, 32'h1234_1234);
        check_eq("hw_haddr_c4", HADDR, 32'h2000_0102);
        check_eq("hw_mready_c4", {31'h0, mready}, 32'h0);
        HREADY = 1'b1;
        step();  // cycle 5
        check_eq("hw_mready_c5", {31'h0, mready}, 32'h1);
        check_eq("hw_merror", {31'h0, merror}, 32'h0);
        check_eq("hw_mrdata_kept", mrdata, 32'h0000_00AA);
        mwrite = 1'b0;
        step();

        // ---------------- word read with two-cycle error response ----------------
        maddr = 16'h0010; msize = 2'b10; mread = 1'b1;
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0BAD_0BAD;
        step();  // cycle 1
        check_eq("er_htrans_c1", {30'h0, HTRANS}, 32'h2);
        check_eq("er_haddr", HADDR, 32'h2000_0010);
        step();  // cycle 2: DATA
        HRESP = 1'b1; HREADY = 1'b0;
        step();  // cycle 3: ERR
        check_eq("er_mready_c3", {31'h0, mready}, 32'h0);
        check_eq("er_htrans_c3", {30'h0, HTRANS}, 32'h0);
        HREADY = 1'b1;
        step();  // cycle 4
        check_eq("er_mready", {31'h0, mready}, 32'h1);
        check_eq("er_merror", {31'h0, merror}, 32'h1);
        check_eq("er_mrdata_kept", mrdata, 32'h0000_00AA);
        mread = 1'b0; HRESP = 1'b0;
        step();
        check_eq("er_merror_clr", {31'h0, merror}, 32'h0);

        // ---------------- misaligned word ----------------
        maddr = 16'h0002; msize = 2'b10; mread = 1'b1;
        step();
        check_eq("mis_htrans", {30'h0, HTRANS}, 32'h0);
        check_eq("mis_mready", {31'h0, mready}, 32'h1);
        check_eq("mis_merror", {31'h0, merror}, 32'h1);
        mread = 1'b0;
        step();
        check_eq("mis_mready_off", {31'h0, mready}, 32'h0);
        check_eq("mis_htrans_c2", {30'h0, HTRANS}, 32'h0);

        // ---------------- read and write together ----------------
        maddr = 16'h0000; msize = 2'b00; mread = 1'b1; mwrite = 1'b1;
        step();
        check_eq("rw_htrans", {30'h0, HTRANS}, 32'h0);
        check_eq("rw_mready", {31'h0, mready}, 32'h1);
        check_eq("rw_merror", {31'h0, merror}, 32'h1);
        mread = 1'b0; mwrite = 1'b0;
        step();

        // ---------------- illegal size ----------------
        maddr = 16'h0000; msize = 2'b11; mwrite = 1'b1;
        step();
        check_eq("sz3_htrans", {30'h0, HTRANS}, 32'h0);
        check_eq("sz3_merror", {31'h0, merror}, 32'h1);
        mwrite = 1'b0;
        step();

        // ---------------- halfword read, request dropped early ----------------
        maddr = 16'h0006; msize = 2'b01; mread = 1'b1;
        HREADY = 1'b1; HRDATA = 32'hCAFE_BABE;
        step();  // cycle 1
        check_eq("dr_htrans_c1", {30'h0, HTRANS}, 32'h2);
        mread = 1'b0;
        step();  // cycle 2
        step();  // cycle 3
        check_eq("dr_mready", {31'h0, mready}, 32'h1);
        check_eq("dr_mrdata", mrdata, 32'h0000_CAFE);
        step();

        // ---------------- reset during stalled data phase ----------------
        maddr = 16'h0004; msize = 2'b10; mwdata = 32'hDEAD_BEEF; mwrite = 1'b1;
        HREADY = 1'b1;
        step();  // cycle 1
        check_eq("rs_htrans_c1", {30'h0, HTRANS}, 32'h2);
        step();  // cycle 2: DATA
        check_eq("rs_hwdata", HWDATA, 32'hDEAD_BEEF);
        HREADY = 1'b0; Resetn = 1'b0;
        step();  // cycle 3
        check_eq("rs_htrans", {30'h0, HTRANS}, 32'h0);
        check_eq("rs_haddr", HADDR, 32'h2000_0000);
        check_eq("rs_hwdata0", HWDATA, 32'h0);
        check_eq("rs_hwrite", {31'h0, HWRITE}, 32'h0);
        check_eq("rs_hsize", {30'h0, HSIZE}, 32'h0);
        check_eq("rs_mrdata", mrdata, 32'h0);
        check_eq("rs_mready", {31'h0, mready}, 32'h0);
        Resetn = 1'b1; mwrite = 1'b0; HREADY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("rs_no_mready", {31'h0, mready}, 32'h0);
        end

        // ---------------- back-to-back held request ----------------
        maddr = 16'h0001; msize = 2'b00; mread = 1'b1;
        HREADY = 1'b1; HRDATA = 32'h1122_3344;
        nonseq_since = 0; n_nonseq = 0; n_pulse = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (HTRANS == 2'b10) begin
                nonseq_since++;
                n_nonseq++;
            end
            if (mready) begin
                n_pulse++;
                check_eq("b2b_nonseq_per_pulse", nonseq_since, 32'd1);
                nonseq_since = 0;
            end
        end
        check_eq("b2b_nonseq_cnt", n_nonseq, 32'd3);
        check_eq("b2b_pulse_cnt", n_pulse, 32'd3);
        check_eq("b2b_mrdata", mrdata, 32'h0000_0033);
        mread = 1'b0;
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_ahb_master.md
MEM_AHB_MASTER -- requirements
Module: mem_ahb_master

Interface
REQ-001 Parameter ADDR_W, default 16: width of maddr; legal range 2..28.
REQ-002 Parameter BASE_ADDR, default 32'h2000_0000: added to zero-extended maddr to form HADDR.
REQ-003 Clk  in  1: single clock; all flops rise-edge.
REQ-004 Resetn  in  1: reset is synchronous and active-low.
REQ-005 maddr  in  ADDR_W: byte address of request.
REQ-006 msize  in  2: 00 byte, 01 halfword, 10 word; 11 illegal.
REQ-007 mwdata  in  32: write data, right-justified.
REQ-008 mread / mwrite  in  1 each: level request, held until mready.
REQ-009 mrdata  out  32: read data, right-justified, zero-extended.
REQ-010 mready  out  1: one-cycle completion pulse.
REQ-011 merror  out  1: valid with mready; 1 = failed transfer.
REQ-012 HADDR out 32, HTRANS out 2, HWRITE out 1, HSIZE out 2, HWDATA out 32, HSEL out 1, HMASTLOCK out 1: AHB-Lite master outputs.
REQ-013 HREADY in 1, HRDATA in 32, HRESP in 1: AHB-Lite slave responses.

Function
REQ-014 States IDLE, ADDR, DATA, ERR, DONE; HSEL tied 1, HMASTLOCK tied 0.
REQ-015 IDLE: when mread xor mwrite at edge, latch maddr, msize, mwdata, direction; go ADDR.
REQ-016 IDLE with mread and mwrite both 1, msize=11, or misaligned (halfword addr[0]=1, word addr[1:0]!=0): go DONE with merror=1; HTRANS stays IDLE.
REQ-017 ADDR: HTRANS=2'b10 (NONSEQ), HADDR=BASE_ADDR+latched maddr, HSIZE=latched msize, HWRITE=latched direction; stay while HREADY=0, go DATA on HREADY=1.
REQ-018 DATA: HTRANS=2'b00; HWDATA replicated across lanes (byte on all 4, halfword on both halves, word as-is), held stable throughout.
REQ-019 DATA, HREADY=1, HRESP=0: capture lane-selected HRDATA (by HADDR[1:0]/size) into mrdata on reads; go DONE, merror=0.
REQ-020 DATA, HRESP=1, HREADY=0: go ERR; ERR waits for HREADY=1 then goes DONE with merror=1; mrdata unchanged.
REQ-021 DONE: mready=1 for exactly one cycle, then IDLE; requests ignored in DONE.
REQ-022 Zero-wait latency: request sampled edge 0, NONSEQ cycle 1, data phase cycle 2, mready high cycle 3; each HREADY=0 cycle adds one.
REQ-023 Only one transfer outstanding; no pipelining of next address into current data phase.
REQ-024 HADDR, HSIZE, HWRITE held stable from ADDR until leaving DATA/ERR.
REQ-025 mready, merror, mrdata registered; mrdata holds last read value until next successful read.
REQ-026 Request dropped by requester before mready: transfer still completes on bus; mready still pulses.
REQ-027 HADDR addition wraps modulo 2^32.

Reset
REQ-028 Resetn=0 at edge: state IDLE, HTRANS=00, HWRITE=0, HSIZE=00, HADDR=BASE_ADDR, HWDATA=0, mrdata=0, mready=0, merror=0.
REQ-029 Reset mid-transfer abandons it; HTRANS=00 from the next cycle; no mready issued.

Verification
REQ-030 Byte read maddr=16'h0003, HREADY=1, HRDATA=32'hAABBCCDD -> HADDR=32'h2000_0003, HSIZE=00, mrdata=32'h000000AA, mready in cycle 3.
REQ-031 Halfword write maddr=16'h0102, mwdata=32'h1234, 2 wait states -> HWDATA=32'h1234_1234 held 3 data cycles, mready in cycle 5, merror=0.
REQ-032 Word read, slave HRESP=1 two-cycle error -> ERR entered, mready=1, merror=1, mrdata unchanged.
REQ-033 Word request maddr=16'h0002, and mread=mwrite=1 -> HTRANS never NONSEQ, mready=1, merror=1 in cycle after sampling.
REQ-034 Resetn=0 during DATA with HREADY=0 -> next cycle HTRANS=00, all outputs at REQ-028 values, no mready.
REQ-035 Requests held high back-to-back -> exactly one NONSEQ per mready pulse, one DONE cycle between transfers.
